layer_line_scanner: RTL

//  Downstream consumer of the layer header store. Per scanline, walks layers 0..NUM_LAYERS-1
//  by driving the header read index and culling each header against the latched line Y.

---
 rtl/layer_pipe_pkg.sv | 40 ++++
 rtl/hit_fifo.sv | 55 +++++
 rtl/layer_line_scanner.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/layer_pipe_pkg.sv
// Shared definitions for the layer pipeline: header field layout, hit entry and scan FSM states.
package layer_pipe_pkg;

  // Header field bit offsets (each field is 16 bits unless noted).
  localparam int unsigned FIELD_W     = 16;
  localparam int unsigned FLAGS_LSB   = 0;
  localparam int unsigned W_LSB       = 16;
  localparam int unsigned H_LSB       = 32;
  localparam int unsigned X_LSB       = 48;
  localparam int unsigned Y_LSB       = 64;
  localparam int unsigned AUX_TXT_LSB = 80;
  localparam int unsigned AUX_SPR_LSB = 96;
  localparam int unsigned FRAME_LSB   = 120;  // 8-bit sprite frame number
  localparam int unsigned FRAME_W     = 8;

  // Flag bit positions within the flags field.
  localparam int unsigned FLAG_POPULATED = 0;
  localparam int unsigned FLAG_SPRITE    = 1;
  localparam int unsigned FLAG_HIDDEN    = 2;
  localparam int unsigned FLAG_ANIMATE   = 3;

  localparam int unsigned HIT_LAYER_W = 5;

  typedef struct packed {
    logic [HIT_LAYER_W-1:0] layer;
    logic                   is_text;
    logic [FIELD_W-1:0]     row;
    logic [FIELD_W-1:0]     x;
    logic [FIELD_W-1:0]     width;
    logic [FIELD_W-1:0]     aux;
  } hit_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } scan_state_e;

endpackage

// File: rtl/hit_fifo.sv
// Small synchronous FIFO with flush; pop frees a slot for a same-cycle push when full.
module hit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush discards all entries and any same-cycle push/pop.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/layer_line_scanner.sv
// Per-scanline layer walker: culls each layer header against the line Y and queues hits.
module layer_line_scanner
  import layer_pipe_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 32,
  parameter int unsigned LAYER_W    = 5,
  parameter int unsigned HDR_W      = 128,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_line_start,
  input  logic [15:0]        i_line_y,
  output logic [LAYER_W-1:0] o_layer,
  input  logic [HDR_W-1:0]   i_curr_layer_header,
  output logic               o_hit_valid,
  input  logic               i_hit_ready,
  output logic [LAYER_W-1:0] o_hit_layer,
  output logic               o_hit_is_text,
  output logic [15:0]        o_hit_row,
  output logic [15:0]        o_hit_x,
  output logic [15:0]        o_hit_width,
  output logic [15:0]        o_hit_aux,
  output logic               o_busy,
  output logic               o_line_done,
  output logic               o_line_overrun
);

  // One extra bit so the end of the walk is seen without wrapping.
  localparam int unsigned       IdxW      = LAYER_W + 1;
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NUM_LAYERS - 1);
  localparam logic [LAYER_W-1:0] LastLayer = LAYER_W'(NUM_LAYERS - 1);
  localparam logic signed [15:0] XLimit   = 16'(SCREEN_W);
  localparam int unsigned       HitW      = $bits(hit_entry_t);

  scan_state_e       r_state;
  scan_state_e       w_state_d;
  logic [IdxW-1:0]   r_idx;
  logic [IdxW-1:0]   w_idx_d;
  logic [15:0]       r_line_y;
  logic              r_overrun;

  logic [15:0]       w_flags;
  logic [15:0]       w_w;
  logic [15:0]       w_h;
  logic [15:0]       w_x;
  logic [15:0]       w_y;
  logic signed [16:0] w_row;
  logic signed [17:0] w_x_right;
  logic              w_hit;
  logic              w_busy;
  logic              w_push;
  logic              w_flush;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_can_push;
  hit_entry_t        w_entry;
  hit_entry_t        w_head;
  logic              w_unused;

  assign w_flags = i_curr_layer_header[FLAGS_LSB +: FIELD_W];
  assign w_w     = i_curr_layer_header[W_LSB +: FIELD_W];
  assign w_h     = i_curr_layer_header[H_LSB +: FIELD_W];
  assign w_x     = i_curr_layer_header[X_LSB +: FIELD_W];
  assign w_y     = i_curr_layer_header[Y_LSB +: FIELD_W];

  // Layer ID, animate flag and the reserved aux word do not affect culling.
  assign w_unused = ^{w_flags[15:3], i_curr_layer_header[AUX_SPR_LSB +: 24]};

  // Cull: vertical band test in 17 bits, horizontal overlap test in 18 bits.
  always_comb begin
    w_row     = $signed({r_line_y[15], r_line_y}) - $signed({w_y[15], w_y});
    w_x_right = $signed({{2{w_x[15]}}, w_x}) + $signed({2'b00, w_w});
    w_hit     = w_flags[FLAG_POPULATED] && !w_flags[FLAG_HIDDEN] &&
                (w_w != 16'd0) && (w_h != 16'd0) &&
                !w_row[16] && (w_row[15:0] < w_h) &&
                ($signed(w_x) < XLimit) && (w_x_right > 18'sd0);
  end

  // Assemble the hit entry for the layer currently on the header bus.
  always_comb begin
    w_entry         = '0;
    w_entry.layer   = r_idx[HIT_LAYER_W-1:0];
    w_entry.is_text = ~w_flags[FLAG_SPRITE];
    w_entry.row     = w_row[15:0];
    w_entry.x       = w_x;
    w_entry.width   = w_w;
    w_entry.aux     = w_flags[FLAG_SPRITE] ?
                      {8'h00, i_curr_layer_header[FRAME_LSB +: FRAME_W]} :
                      i_curr_layer_header[AUX_TXT_LSB +: FIELD_W];
  end

  assign w_busy     = (r_state == StScan) || (r_state == StDrain);
  assign w_pop      = ~w_empty & i_hit_ready;
  assign w_can_push = ~w_full | w_pop;

  // Next-state logic; a new line start overrides whatever the FSM was doing.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_push    = 1'b0;
    w_flush   = 1'b0;
    unique case (r_state)
      StIdle: w_state_d = StIdle;
      StScan: begin
        // A hit that cannot be queued holds the index and retries.
        if (!w_hit || w_can_push) begin
          w_push  = w_hit;
          w_idx_d = r_idx + 1'b1;
          if (r_idx == LastIdx) w_state_d = StDrain;
        end
      end
      StDrain: if (w_empty) w_state_d = StDone;
      StDone: begin
        w_state_d = StIdle;
        w_idx_d   = '0;
      end
      default: w_state_d = StIdle;
    endcase
    if (i_line_start) begin
      w_state_d = StScan;
      w_idx_d   = '0;
      w_push    = 1'b0;
      w_flush   = w_busy;
    end
  end

  // State, index, latched line Y and overrun pulse registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_line_y  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_overrun <= i_line_start & w_busy;
      if (i_line_start) r_line_y <= i_line_y;
    end
  end

  hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HitW)
  ) u_hit_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Index sits one past the last layer while draining; clamp the read index.
  assign o_layer        = (r_idx > LastIdx) ? LastLayer : r_idx[LAYER_W-1:0];
  assign o_hit_valid    = ~w_empty;
  assign o_hit_layer    = LAYER_W'(w_head.layer);
  assign o_hit_is_text  = w_head.is_text;
  assign o_hit_row      = w_head.row;
  assign o_hit_x        = w_head.x;
  assign o_hit_width    = w_head.width;
  assign o_hit_aux      = w_head.aux;
  assign o_busy         = w_busy;
  assign o_line_done    = (r_state == StDone);
  assign o_line_overrun = r_overrun;

endmodule
